// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and constants for the packet-granular AXI-Stream round-robin arbiter.
package axis_arb_pkg;

    // Arbiter owns no packet (IDLE) or is forwarding one packet (XFER).
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Width of the per-source packet counters in the statistics build.
    localparam int STATS_CNT_W = 16;

    // Index width for n sources; never below one bit so single-bit selects stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the NUM_SRC upstream AXI-Stream senders and the single shared downstream port.
//
// Handshake: a beat transfers on a rising clk edge where t_valid && t_ready are both high.
// A sender keeps t_valid, t_data, t_last and byte_enable stable until its beat is accepted;
// t_ready may change freely and never waits on t_valid.
interface axis_rr_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC*WIDTH-1:0]     s_t_data;
    logic [NUM_SRC-1:0]           s_t_valid;
    logic [NUM_SRC-1:0]           s_t_last;
    logic [NUM_SRC*WIDTH/8-1:0]   s_byte_enable;
    logic [NUM_SRC-1:0]           s_t_ready;

    logic [WIDTH-1:0]             m_t_data;
    logic                         m_t_valid;
    logic                         m_t_last;
    logic [WIDTH/8-1:0]           m_byte_enable;
    logic                         m_t_ready;

    // Arbiter side: accepts the sources, drives the shared output.
    modport slave (
        input  s_t_data, s_t_valid, s_t_last, s_byte_enable, m_t_ready,
        output s_t_ready, m_t_data, m_t_valid, m_t_last, m_byte_enable
    );

    // Environment side: the upstream senders plus the downstream sink.
    modport master (
        output s_t_data, s_t_valid, s_t_last, s_byte_enable, m_t_ready,
        input  s_t_ready, m_t_data, m_t_valid, m_t_last, m_byte_enable
    );
endinterface

// File: rtl/axis_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning from ptr_i upward, wrapping.
module rr_picker
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [IDX_W-1:0] scan_c;
    logic             found_c;

    // Walk ptr, ptr+1, ... with an explicit wrap compare so non-power-of-two counts work.
    always_comb begin
        winner_o  = '0;
        found_c   = 1'b0;
        scan_c    = ptr_i;
        any_req_o = |req_i;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found_c && req_i[scan_c]) begin
                winner_o = scan_c;
                found_c  = 1'b1;
            end
            scan_c = (scan_c == IDX_W'(NUM_SRC - 1)) ? '0 : scan_c + 1'b1;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SRC AXI-Stream senders share one output.
// The grant is taken in IDLE (one bubble cycle) and held until the t_last beat, so packets
// never interleave. Optional per-source packet counters are built when AXIS_ARB_STATS_EN
// is defined (adds stats_clr input and pkt_count output).
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    axis_rr_arbiter_if.slave   bus,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output arb_state_t         dbg_state_o,
    output logic [IDX_W-1:0]   dbg_rr_ptr_o
`ifdef AXIS_ARB_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [NUM_SRC*STATS_CNT_W-1:0] pkt_count
`endif
);

    localparam int BE_W = WIDTH / 8;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;

    logic [WIDTH-1:0]   sel_data;
    logic [BE_W-1:0]    sel_be;
    logic               sel_valid;
    logic               sel_last;

    logic [WIDTH-1:0]   m_data_c;
    logic [BE_W-1:0]    m_be_c;
    logic               m_valid_c;
    logic               m_last_c;
    logic [NUM_SRC-1:0] s_ready_c;
    logic               beat_last;

    rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req_i     (bus.s_t_valid),
        .ptr_i     (rr_ptr_q),
        .winner_o  (pick_idx),
        .any_req_o (any_req)
    );

    // Select the fields of the source named by the registered grant.
    always_comb begin
        sel_data  = '0;
        sel_be    = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = bus.s_t_data[i*WIDTH +: WIDTH];
                sel_be    = bus.s_byte_enable[i*BE_W +: BE_W];
                sel_valid = bus.s_t_valid[i];
                sel_last  = bus.s_t_last[i];
            end
        end
    end

    // Next-state and output decode: outputs are all-zero unless a packet is owned.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        m_data_c  = '0;
        m_be_c    = '0;
        m_valid_c = 1'b0;
        m_last_c  = 1'b0;
        s_ready_c = '0;
        beat_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_data_c  = sel_data;
                m_be_c    = sel_be;
                m_valid_c = sel_valid;
                m_last_c  = sel_last;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == IDX_W'(i)) begin
                        s_ready_c[i] = bus.m_t_ready;
                    end
                end
                // A stalled owner (valid low) keeps the grant; only its t_last beat frees it.
                if (sel_valid && bus.m_t_ready && sel_last) begin
                    beat_last = 1'b1;
                    rr_ptr_d  = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration registers; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.m_t_data      = m_data_c;
    assign bus.m_byte_enable = m_be_c;
    assign bus.m_t_valid     = m_valid_c;
    assign bus.m_t_last      = m_last_c;
    assign bus.s_t_ready     = s_ready_c;

    assign grant_idx    = grant_q;
    assign busy         = (state_q == XFER);
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

`ifdef AXIS_ARB_STATS_EN
    logic [NUM_SRC*STATS_CNT_W-1:0] cnt_q, cnt_d;

    // Count completed packets per owner; a clear in the same cycle takes priority.
    always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
            cnt_d = '0;
        end else if (beat_last) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == IDX_W'(i)) begin
                    cnt_d[i*STATS_CNT_W +: STATS_CNT_W] =
                        cnt_q[i*STATS_CNT_W +: STATS_CNT_W] + 1'b1;
                end
            end
        end
    end

    // Counter storage, wrapping naturally at 16'hFFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed, table-driven bench for axis_rr_arbiter (NUM_SRC=4, WIDTH=32).
// Each table row drives inputs for one cycle and lists the outputs expected in that cycle.
module tb_axis_rr_arbiter;
    import axis_arb_pkg::*;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       busy;
        logic [1:0] grant;
        logic [1:0] rr;
        logic       mv;
        logic       ml;
        logic [3:0] sr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  grant_idx;
    logic        busy;
    arb_state_t  dbg_state;
    logic [1:0]  dbg_rr;
`ifdef AXIS_ARB_STATS_EN
    logic        stats_clr;
    logic [63:0] pkt_count;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[$];
    logic [31:0] exp_q[$];

    axis_rr_arbiter_if #(.WIDTH(32), .NUM_SRC(4)) bus ();

    axis_rr_arbiter #(
        .WIDTH   (32),
        .NUM_SRC (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr)
`ifdef AXIS_ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .pkt_count    (pkt_count)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Deterministic per-source payload: source id in the top byte, row tag in the low byte.
    function automatic logic [31:0] src_data(input int s, input logic [7:0] tag);
        return {8'hA0 + 8'(s), 16'h00C3, tag};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic r,
                                input logic busy_e, input logic [1:0] grant_e,
                                input logic [1:0] rr_e, input logic mv, input logic ml,
                                input logic [3:0] sr);
        vec_t t;
        t.v = v; t.l = l; t.r = r; t.busy = busy_e; t.grant = grant_e;
        t.rr = rr_e; t.mv = mv; t.ml = ml; t.sr = sr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r,
                         input logic [7:0] tag);
        bus.s_t_valid = v;
        bus.s_t_last  = l;
        bus.m_t_ready = r;
        for (int i = 0; i < 4; i++) begin
            bus.s_t_data[i*32 +: 32]    = src_data(i, tag);
            bus.s_byte_enable[i*4 +: 4] = tag[3:0] ^ 4'(i);
        end
    endtask

    task automatic run_row(input int idx);
        vec_t        t;
        logic [7:0]  tag;
        logic [31:0] ed;
        logic [3:0]  eb;
        t   = tbl[idx];
        tag = 8'(idx);
        ed  = t.busy ? src_data(int'(t.grant), tag) : 32'h0;
        eb  = t.busy ? (tag[3:0] ^ {2'b00, t.grant}) : 4'h0;
        @(negedge clk);
        drive(t.v, t.l, t.r, tag);
        #1;
        chk($sformatf("r%0d_busy", idx),  64'(busy), 64'(t.busy));
        chk($sformatf("r%0d_state", idx), 64'(dbg_state), 64'(t.busy ? XFER : IDLE));
        chk($sformatf("r%0d_rr", idx),    64'(dbg_rr), 64'(t.rr));
        if (t.busy) chk($sformatf("r%0d_grant", idx), 64'(grant_idx), 64'(t.grant));
        chk($sformatf("r%0d_mvalid", idx), 64'(bus.m_t_valid), 64'(t.mv));
        chk($sformatf("r%0d_mlast", idx),  64'(bus.m_t_last), 64'(t.ml));
        chk($sformatf("r%0d_sready", idx), 64'(bus.s_t_ready), 64'(t.sr));
        chk($sformatf("r%0d_mdata", idx),  64'(bus.m_t_data), 64'(ed));
        chk($sformatf("r%0d_mbe", idx),    64'(bus.m_byte_enable), 64'(eb));
        if (t.mv && t.r) exp_q.push_back(ed);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) run_row(i);
    endtask

    // Scoreboard: every beat seen on the shared output must match the next expected word.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.m_t_valid && bus.m_t_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_beat", 64'(bus.m_t_data), 64'h0);
            end else begin
                chk("sb_beat", 64'(bus.m_t_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Seq 1: lone src2 3-beat packet from rr_ptr=0 (rows 0-4)
        tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 4'b0100));
        tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 4'b0100));
        tbl.push_back(mk(4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 1'b1, 4'b0100));
        tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 4'b0000));
        // Seq 2: all four sources send 2-beat packets continuously (rows 5-19)
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 4'b0001));
        tbl.push_back(mk(4'b1111, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 4'b0001));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 4'b0010));
        tbl.push_back(mk(4'b1111, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 4'b0010));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 4'b0100));
        tbl.push_back(mk(4'b1111, 4'b0100, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 4'b0100));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 4'b1000));
        tbl.push_back(mk(4'b1111, 4'b1000, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 4'b1000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 4'b0001));
        tbl.push_back(mk(4'b1111, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 4'b0001));
        // Seq 3: src1 owns, m_t_ready toggles, src0 waits (rows 20-29)
        tbl.push_back(mk(4'b0011, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b0011, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 4'b0010));
        tbl.push_back(mk(4'b0011, 4'b0000, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b0011, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 4'b0010));
        tbl.push_back(mk(4'b0011, 4'b0010, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 4'b0000));
        tbl.push_back(mk(4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 4'b0010));
        tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 4'b0001));
        tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000));
        // Seq 4: src3 drops valid for 5 cycles mid-packet while src0 requests (rows 30-37)
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 4'b1000));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 1'b1, 2'd3, 2'd1, 1'b0, 1'b0, 4'b1000));
        tbl.push_back(mk(4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 1'b1, 4'b1000));
        // Single-beat src1 packet, then src2 starts a packet (rows 38-41)
        tbl.push_back(mk(4'b0010, 4'b0010, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 4'b0010));
        tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 4'b0100));
        // After mid-packet reset: src0 beats src3, then src3 (rows 42-46)
        tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1001, 4'b0001, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 4'b0001));
        tbl.push_back(mk(4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 1'b1, 4'b1000));
        tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 4'b0000));

        // Reset state, with every source requesting to show IDLE keeps outputs at zero
        rst = 1'b1;
`ifdef AXIS_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        drive(4'b1111, 4'b1111, 1'b1, 8'h55);
        #2;
        chk("rst_mvalid", 64'(bus.m_t_valid), 64'h0);
        chk("rst_mlast",  64'(bus.m_t_last), 64'h0);
        chk("rst_mdata",  64'(bus.m_t_data), 64'h0);
        chk("rst_mbe",    64'(bus.m_byte_enable), 64'h0);
        chk("rst_sready", 64'(bus.s_t_ready), 64'h0);
        chk("rst_busy",   64'(busy), 64'h0);
        chk("rst_grant",  64'(grant_idx), 64'h0);
        chk("rst_rr",     64'(dbg_rr), 64'h0);
        chk("rst_state",  64'(dbg_state), 64'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        rst = 1'b0;

        run_rows(0, 5);

        // Fresh pointer so the fairness sequence starts from source 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_rows(5, 42);

        // Async reset between edges while src2 owns the bus
        @(negedge clk);
        drive(4'b0100, 4'b0000, 1'b1, 8'h80);
        #1;
        chk("pre_rst_mvalid", 64'(bus.m_t_valid), 64'h1);
        chk("pre_rst_grant",  64'(grant_idx), 64'h2);
        exp_q.push_back(src_data(2, 8'h80));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mvalid", 64'(bus.m_t_valid), 64'h0);
        chk("async_rst_sready", 64'(bus.s_t_ready), 64'h0);
        chk("async_rst_busy",   64'(busy), 64'h0);
        chk("async_rst_state",  64'(dbg_state), 64'(IDLE));
        chk("async_rst_rr",     64'(dbg_rr), 64'h0);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        rst = 1'b0;

        run_rows(42, 47);

`ifdef AXIS_ARB_STATS_EN
        // Packet counters: clear, count 5 src1 packets, then clear colliding with a 6th
        @(negedge clk);
        stats_clr = 1'b1;
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("stats_cleared", 64'(pkt_count), 64'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(4'b0010, 4'b0010, 1'b1, 8'(8'hC0 + k));
            @(negedge clk);
            #1;
            exp_q.push_back(src_data(1, 8'(8'hC0 + k)));
        end
        @(negedge clk);
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        #1;
        chk("stats_cnt1_5",  64'(pkt_count[31:16]), 64'd5);
        chk("stats_others",  64'({pkt_count[63:32], pkt_count[15:0]}), 64'h0);
        @(negedge clk);
        drive(4'b0010, 4'b0010, 1'b1, 8'hD0);
        @(negedge clk);
        stats_clr = 1'b1;
        #1;
        exp_q.push_back(src_data(1, 8'hD0));
        chk("stats_before_clr", 64'(pkt_count[31:16]), 64'd5);
        @(negedge clk);
        stats_clr = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1, 8'h00);
        #1;
        chk("stats_clr_wins", 64'(pkt_count), 64'h0);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drain", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
